// File: rtl/tick_universal_shift_reg_pkg.sv
// Shared definitions for tick_universal_shift_reg.
// Holds the operation mode encodings and the default register and counter widths.
package tick_universal_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/tick_universal_shift_reg_rise_edge_detect.sv
// rise_edge_detect: finds rising edges of a slow level signal that is sampled
// as data in the fast clock domain.
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset
//   d    - level signal to watch (treated as data, never as a clock)
//   step - high for the cycle in which d is high and its registered copy is low
// d_q resets to 1 so that a level that is already high when reset releases
// is not mistaken for a fresh rising edge.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic step
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b1;
    else     d_q <= d;
  end

  assign step = d & ~d_q;

endmodule

// File: rtl/tick_universal_shift_reg.sv
// tick_universal_shift_reg: universal shift register stepped by rising edges
// of a divided clock that is sampled as data on i_clk.
// Ports:
//   i_clk      - system clock, the only clock
//   i_rst      - asynchronous active-high reset
//   i_div_clk  - divided clock, sampled as data; each rising edge is one step
//   i_en       - step enable; a step seen while low is dropped, not deferred
//   i_mode     - 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   i_sr       - serial input entering the MSB on shift right
//   i_sl       - serial input entering the LSB on shift left
//   i_par      - parallel load data
//   i_rot      - (USR_ROTATE_EN only) 1 turns the shifts into rotates
//   o_q        - register contents
//   o_step     - one-cycle pulse the cycle after a non-hold step updated o_q
//   o_step_cnt - wrapping count of executed non-hold steps
// Build option: define USR_ROTATE_EN to add the i_rot port and rotate support.
module tick_universal_shift_reg
  import tick_universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_div_clk,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_sr,
  input  logic             i_sl,
  input  logic [WIDTH-1:0] i_par,
`ifdef USR_ROTATE_EN
  input  logic             i_rot,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_step,
  output logic [CNT_W-1:0] o_step_cnt
);

  logic             step;
  logic             fire;
  logic             active;
  logic             shr_in;
  logic             shl_in;
  logic [WIDTH-1:0] q_next;

  rise_edge_detect u_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_div_clk),
    .step (step)
  );

  assign fire   = step & i_en;
  assign active = fire && (mode_e'(i_mode) != MODE_HOLD);

`ifdef USR_ROTATE_EN
  assign shr_in = i_rot ? o_q[0]       : i_sr;
  assign shl_in = i_rot ? o_q[WIDTH-1] : i_sl;
`else
  assign shr_in = i_sr;
  assign shl_in = i_sl;
`endif

  always_comb begin
    q_next = o_q;
    case (mode_e'(i_mode))
      MODE_SHR:  q_next = {shr_in, o_q[WIDTH-1:1]};
      MODE_SHL:  q_next = {o_q[WIDTH-2:0], shl_in};
      MODE_LOAD: q_next = i_par;
      default:   q_next = o_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_q        <= '0;
      o_step     <= 1'b0;
      o_step_cnt <= '0;
    end else begin
      o_step <= active;
      if (fire) o_q <= q_next;
      if (active) o_step_cnt <= o_step_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/tick_universal_shift_reg.md
TICK_UNIVERSAL_SHIFT_REG -- requirements
Module: tick_universal_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 4, register width in bits (legal range 2..16).
REQ-002 Parameter: CNT_W, default 8, width of the step counter.
REQ-003 Port: i_clk  input  1  system clock (100 MHz board clock); the only clock.
REQ-004 Port: i_rst  input  1  asynchronous, active-high reset.
REQ-005 Port: i_div_clk  input  1  divided clock from the clock divider, treated as data and sampled on i_clk, never used as a clock.
REQ-006 Port: i_en  input  1  step enable; when low, detected steps are ignored.
REQ-007 Port: i_mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 Port: i_sr  input  1  serial in for shift right (enters MSB).
REQ-009 Port: i_sl  input  1  serial in for shift left (enters LSB).
REQ-010 Port: i_par  input  WIDTH  parallel load data.
REQ-011 Port: o_q  output  WIDTH  register contents.
REQ-012 Port: o_step  output  1  one-i_clk pulse, the cycle after o_q is updated by a non-hold step.
REQ-013 Port: o_step_cnt  output  CNT_W  count of executed non-hold steps.

Function
REQ-014 The block SHALL hold a registered sample div_q of i_div_clk, and step = i_div_clk & ~div_q (rising edge of the divided clock).
REQ-015 On the i_clk edge where step=1 and i_en=1, the block SHALL sample i_mode, i_sr, i_sl and i_par and update o_q at that same edge (zero extra latency after edge detection).
REQ-016 Mode 01: o_q <= {i_sr, o_q[WIDTH-1:1]}; mode 10: o_q <= {o_q[WIDTH-2:0], i_sl}; mode 11: o_q <= i_par; mode 00: o_q unchanged.
REQ-017 With step=0 or i_en=0, o_q, o_step_cnt SHALL hold and o_step SHALL be 0 on the next cycle.
REQ-018 o_step SHALL be 1 exactly one cycle after each executed step whose mode is not 00; never two consecutive cycles.
REQ-019 o_step_cnt SHALL increment by 1 per executed non-hold step and wrap from 2^CNT_W-1 to 0 without flag.
REQ-020 A high level on i_div_clk lasting many i_clk cycles SHALL produce exactly one step; a falling edge SHALL produce none.
REQ-021 Changes of i_mode/i_par between steps SHALL have no effect on o_q.
REQ-022 i_en deasserted during the step cycle SHALL cancel that step entirely; it is not deferred.

Reset
REQ-023 Asserting i_rst SHALL asynchronously set o_q=0, o_step=0, o_step_cnt=0, div_q=1.
REQ-024 div_q resetting to 1 SHALL guarantee no step on the first cycle after reset release, even with i_div_clk high.
REQ-025 Reset asserted mid-operation SHALL discard any step in the same cycle.

Configuration
REQ-026 Macro USR_ROTATE_EN: when defined, the block SHALL add input i_rot (1 bit); with i_rot=1 mode 01 rotates right (o_q[0] enters MSB) and mode 10 rotates left (o_q[WIDTH-1] enters LSB), ignoring i_sr/i_sl; with i_rot=0 or macro undefined, behaviour is REQ-016 and port i_rot SHALL not exist.

Structure
REQ-027 A shared package SHALL hold the mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and default WIDTH/CNT_W constants.
REQ-028 One sub-module, rise_edge_detect (div_q register plus step output, reset value 1), SHALL be instantiated; the shift datapath and counter stay in the top.

Verification
REQ-029 Reset with i_div_clk=1, release -> no step, o_q=0, o_step_cnt=0 for 10 cycles.
REQ-030 Mode 11, i_par=4'b1011, one i_div_clk rise -> o_q=1011 at that edge, o_step=1 next cycle, o_step_cnt=1.
REQ-031 From 1011, mode 01, i_sr=0, 2 rises -> o_q=0101 then 0010; mode 10, i_sl=1, one rise -> 0101.
REQ-032 i_div_clk held high 50 cycles in mode 01 -> exactly one shift; mode 00 rise -> o_q unchanged, o_step=0, count unchanged.
REQ-033 i_en=0 during a rise -> no update; 256 non-hold steps from reset -> o_step_cnt wraps to 0.
REQ-034 USR_ROTATE_EN defined, o_q=1000, i_rot=1, mode 10 rise -> o_q=0001; i_rst pulsed mid-run -> all outputs 0 immediately.
